cmp_seq: RTL and testbench

- Sequenced magnitude comparator for WIDTH-bit operands.
- Walks the operands MSB-first in 4-bit slices, one slice per clock, using a single 4-bit greater/less/equal slice compare.
- Stops at the first differing slice, or scans all slices if configured for constant latency.
- Valid/ready handshakes on input and output; sits between operand producers and consumers that need A>B, B>A or A==B flags.

---
 rtl/cmp_seq.sv | 165 ++++++++++++++++
 tb/tb_cmp_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq.sv
// -----------------------------------------------------------------------------
// cmp_seq - sequenced unsigned magnitude comparator.
//
// Walks two WIDTH-bit operands MSB-first in 4-bit slices, one slice per clock,
// through a single 4-bit greater/less compare. With EARLY_EXIT=1 the scan stops
// at the first differing slice; with EARLY_EXIT=0 every slice is examined so
// the latency is constant, but the first (most significant) decision wins.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a/b present
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit unsigned operands, sampled on the accept edge
//   out_valid  result flags valid (DONE state)
//   out_ready  consumer accepts the result
//   la         A > B
//   lb         B > A
//   eq         A == B
//   cycles     number of slices examined for this result
// -----------------------------------------------------------------------------
module cmp_seq #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          la,
    output logic                          lb,
    output logic                          eq,
    output logic [$clog2(WIDTH/4):0]      cycles
);

    localparam int SLICES = WIDTH / 4;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int CW     = $clog2(WIDTH / 4) + 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(SLICES - 1);

    generate
        if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("cmp_seq: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             la_r;
    logic             lb_r;
    logic             eq_r;
    logic [CW-1:0]    cycles_r;
    logic             out_valid_r;

    logic [3:0]       a_sl_s;
    logic [3:0]       b_sl_s;
    logic [1:0]       cmp_s;
    logic             gt_s;
    logic             lt_s;
    logic             decided_s;

    // 4-bit unsigned slice compare: returns {x > y, x < y}.
    function automatic logic [1:0] slice_cmp(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] r;
        r = {(x > y), (x < y)};
        return r;
    endfunction

    // Select the current slice of the registered operands and compare it.
    always_comb begin
        a_sl_s = 4'(a_r >> {idx_r, 2'b00});
        b_sl_s = 4'(b_r >> {idx_r, 2'b00});
        cmp_s  = slice_cmp(a_sl_s, b_sl_s);
    end

    assign gt_s      = cmp_s[1];
    assign lt_s      = cmp_s[0];
    // A decision, once recorded, is never overridden by less significant slices.
    assign decided_s = la_r | lb_r;

    // Sequencer: operand capture, slice-by-slice compare, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_TOP;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            la_r        <= 1'b0;
            lb_r        <= 1'b0;
            eq_r        <= 1'b0;
            cycles_r    <= {CW{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        idx_r    <= IDX_TOP;
                        la_r     <= 1'b0;
                        lb_r     <= 1'b0;
                        eq_r     <= 1'b0;
                        cycles_r <= {CW{1'b0}};
                        state_r  <= ST_CMP;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CMP: begin
                    cycles_r <= cycles_r + CW'(1);
                    if (!decided_s && gt_s) begin
                        la_r <= 1'b1;
                    end
                    if (!decided_s && lt_s) begin
                        lb_r <= 1'b1;
                    end
                    if (EARLY_EXIT && !decided_s && (gt_s || lt_s)) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else if (idx_r == {IW{1'b0}}) begin
                        // Last slice: equality only if nothing ever differed.
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        eq_r        <= !decided_s && !gt_s && !lt_s;
                    end else begin
                        idx_r       <= idx_r - IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Ready is a decode of the state register, forced low while reset is held.
    assign in_ready  = (state_r == ST_IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign la        = la_r;
    assign lb        = lb_r;
    assign eq        = eq_r;
    assign cycles    = cycles_r;

endmodule

// File: tb/tb_cmp_seq.sv
// -----------------------------------------------------------------------------
// tb_cmp_seq - self-checking bench for cmp_seq (WIDTH=16).
// Instance 0 uses EARLY_EXIT=1, instance 1 uses EARLY_EXIT=0. A behavioural
// model predicts handshakes, latency and flags from plain arithmetic; directed
// tests additionally pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_cmp_seq;

    logic        clk;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [1:0]  la;
    logic [1:0]  lb;
    logic [1:0]  eq;
    logic [15:0] a [2];
    logic [15:0] b [2];
    logic [2:0]  cyc [2];

    int n_tests = 0;
    int n_fail  = 0;

    cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .la(la[0]), .lb(lb[0]), .eq(eq[0]), .cycles(cyc[0])
    );

    cmp_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .la(la[1]), .lb(lb[1]), .eq(eq[1]), .cycles(cyc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Slices examined: position of the most significant differing nibble, else all.
    function automatic int calc_n(input logic [15:0] x, input logic [15:0] y, input bit ee);
        int n;
        n = 4;
        if (ee) begin
            for (int i = 0; i < 4; i++) begin
                if (((x >> (4 * i)) & 16'h000F) != ((y >> (4 * i)) & 16'h000F)) n = 4 - i;
            end
        end
        return n;
    endfunction

    // ---------------- behavioural model ----------------
    int        m_phase [2] = '{0, 0};   // 0 idle, 1 busy, 2 result held
    int        m_left  [2] = '{0, 0};
    logic [1:0] m_la = 2'b00;
    logic [1:0] m_lb = 2'b00;
    logic [1:0] m_eq = 2'b00;
    int        m_cyc   [2] = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_phase[k] <= 0;
                m_la[k]    <= 1'b0;
                m_lb[k]    <= 1'b0;
                m_eq[k]    <= 1'b0;
                m_cyc[k]   <= 0;
            end else if (m_phase[k] == 0) begin
                if (in_valid[k]) begin
                    m_phase[k] <= 1;
                    m_left[k]  <= calc_n(a[k], b[k], k == 0);
                    m_cyc[k]   <= calc_n(a[k], b[k], k == 0);
                    m_la[k]    <= a[k] > b[k];
                    m_lb[k]    <= a[k] < b[k];
                    m_eq[k]    <= a[k] == b[k];
                end
            end else if (m_phase[k] == 1) begin
                if (m_left[k] == 1) m_phase[k] <= 2;
                else m_left[k] <= m_left[k] - 1;
            end else begin
                if (out_ready[k]) m_phase[k] <= 0;
            end
        end
    end

    // Compare every cycle; flags are only meaningful outside an active scan.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("model_in_ready", k, in_ready[k], (m_phase[k] == 0) && !rst);
            chk("model_out_valid", k, out_valid[k], m_phase[k] == 2);
            if (m_phase[k] != 1) begin
                chk("model_la", k, la[k], m_la[k]);
                chk("model_lb", k, lb[k], m_lb[k]);
                chk("model_eq", k, eq[k], m_eq[k]);
                chk("model_cycles", k, cyc[k], m_cyc[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic accept(input int k, input logic [15:0] av, input logic [15:0] bv, input bit keep);
        bit ok;
        ok = 1'b0;
        a[k] = av;
        b[k] = bv;
        in_valid[k] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", k, ok, 1'b1);
        @(posedge clk);
        #1;
        if (!keep) in_valid[k] = 1'b0;
    endtask

    // Called just after the accept edge; lat is the cycle in which out_valid rises.
    task automatic wait_result(input int k, input int lat, input logic ela, input logic elb,
                               input logic eeq, input int ecyc);
        int c;
        bit found;
        found = 1'b0;
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid[k]) begin
                found = 1'b1;
                break;
            end
            chk("in_ready_busy", k, in_ready[k], 1'b0);
        end
        chk("latency", k, found ? c : 0, lat);
        if (found) begin
            chk("la", k, la[k], ela);
            chk("lb", k, lb[k], elb);
            chk("eq", k, eq[k], eeq);
            chk("cycles", k, cyc[k], ecyc);
            chk("in_ready_done", k, in_ready[k], 1'b0);
            if (out_ready[k]) begin
                @(negedge clk);
                chk("in_ready_idle", k, in_ready[k], 1'b1);
                chk("out_valid_idle", k, out_valid[k], 1'b0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 2'b00;
        out_ready = 2'b11;
        a[0] = 16'h0000; b[0] = 16'h0000;
        a[1] = 16'h0000; b[1] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready_in_reset", 0, in_ready[0], 1'b0);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_in_ready", k, in_ready[k], 1'b1);
            chk("reset_out_valid", k, out_valid[k], 1'b0);
            chk("reset_flags", k, {la[k], lb[k], eq[k]}, 3'b000);
            chk("reset_cycles", k, cyc[k], 3'd0);
        end

        // EARLY_EXIT=1 directed vectors
        accept(0, 16'h1234, 16'h1234, 1'b0); wait_result(0, 5, 1'b0, 1'b0, 1'b1, 4);
        accept(0, 16'h9000, 16'h8FFF, 1'b0); wait_result(0, 2, 1'b1, 1'b0, 1'b0, 1);
        accept(0, 16'h1230, 16'h1231, 1'b0); wait_result(0, 5, 1'b0, 1'b1, 1'b0, 4);
        accept(0, 16'hFFFF, 16'h0000, 1'b0); wait_result(0, 2, 1'b1, 1'b0, 1'b0, 1);
        accept(0, 16'h0000, 16'h0000, 1'b0); wait_result(0, 5, 1'b0, 1'b0, 1'b1, 4);
        accept(0, 16'h0120, 16'h0130, 1'b0); wait_result(0, 4, 1'b0, 1'b1, 1'b0, 3);

        // EARLY_EXIT=0: constant latency, first decision kept
        accept(1, 16'h9000, 16'h8FFF, 1'b0); wait_result(1, 5, 1'b1, 1'b0, 1'b0, 4);
        accept(1, 16'h1230, 16'h1231, 1'b0); wait_result(1, 5, 1'b0, 1'b1, 1'b0, 4);
        accept(1, 16'hFFFF, 16'h0000, 1'b0); wait_result(1, 5, 1'b1, 1'b0, 1'b0, 4);
        accept(1, 16'h1234, 16'h1234, 1'b0); wait_result(1, 5, 1'b0, 1'b0, 1'b1, 4);
        accept(1, 16'h0F00, 16'h1000, 1'b0); wait_result(1, 5, 1'b0, 1'b1, 1'b0, 4);

        // Output backpressure with new operands waiting
        out_ready[0] = 1'b0;
        accept(0, 16'h0005, 16'h0003, 1'b0);
        wait_result(0, 5, 1'b1, 1'b0, 1'b0, 4);
        a[0] = 16'h00A0;
        b[0] = 16'h00B0;
        in_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", 0, out_valid[0], 1'b1);
            chk("bp_flags", 0, {la[0], lb[0], eq[0]}, 3'b100);
            chk("bp_cycles", 0, cyc[0], 3'd4);
            chk("bp_in_ready", 0, in_ready[0], 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 0, out_valid[0], 1'b1);
        chk("bp_release_in_ready", 0, in_ready[0], 1'b0);
        @(negedge clk);
        chk("bp_idle_in_ready", 0, in_ready[0], 1'b1);
        chk("bp_idle_out_valid", 0, out_valid[0], 1'b0);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        wait_result(0, 4, 1'b0, 1'b1, 1'b0, 3);

        // Reset in cycle 2 of an equal compare
        accept(0, 16'h1234, 16'h1234, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 0, in_ready[0], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_idle", 0, in_ready[0], 1'b1);
        chk("rst_mid_out_valid", 0, out_valid[0], 1'b0);
        chk("rst_mid_flags", 0, {la[0], lb[0], eq[0]}, 3'b000);
        chk("rst_mid_cycles", 0, cyc[0], 3'd0);
        repeat (6) begin
            @(negedge clk);
            chk("rst_no_result", 0, out_valid[0], 1'b0);
        end
        accept(0, 16'h0001, 16'h0002, 1'b0);
        wait_result(0, 5, 1'b0, 1'b1, 1'b0, 4);

        // Back-to-back with in_valid held high
        accept(0, 16'h8000, 16'h7FFF, 1'b1);
        a[0] = 16'h0010;
        b[0] = 16'h0020;
        wait_result(0, 2, 1'b1, 1'b0, 1'b0, 1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        wait_result(0, 4, 1'b0, 1'b1, 1'b0, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
